// File: rtl/freq_pkg.sv
// Shared types and defaults for the frequency-counter measurement sequencer.
package freq_pkg;

   localparam int DEF_CHANNELS       = 4;
   localparam int DEF_SETTLE_CYCLES  = 256;
   localparam int DEF_ARM_CYCLES     = 64;
   localparam int DEF_TIMEOUT_CYCLES = 2_000_000;
   localparam int DEF_CLEAR_CYCLES   = 4;
   localparam int CHAN_W_MAX         = 4;
   localparam int AVG_W              = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_ARM     = 3'd2,
      ST_WAIT    = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_REPORT  = 3'd5,
      ST_CLEAR   = 3'd6,
      ST_DONE    = 3'd7
   } sweep_state_t;

   typedef struct packed {
      logic [CHAN_W_MAX-1:0] chan;
      logic [AVG_W-1:0]      avg;
      logic                  pass;
      logic                  timeout;
   } sweep_result_t;

   // An inverted window (lo > hi) never passes.
   function automatic logic in_window(input logic [AVG_W-1:0] avg,
                                      input logic [AVG_W-1:0] lo,
                                      input logic [AVG_W-1:0] hi);
      return (lo <= hi) && (avg >= lo) && (avg <= hi);
   endfunction

endpackage

// File: rtl/freq_sweep_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module sync_edge (
   input  logic Clock,
   input  logic nReset,
   input  logic async_in,
   output logic rise
);

   logic meta_r, sync_r, sync_d_r, rise_r;

   // Synchronize the input and register a one-cycle pulse on its rising edge.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         meta_r   <= 1'b0;
         sync_r   <= 1'b0;
         sync_d_r <= 1'b0;
         rise_r   <= 1'b0;
      end else begin
         meta_r   <= async_in;
         sync_r   <= meta_r;
         sync_d_r <= sync_r;
         rise_r   <= sync_r & ~sync_d_r;
      end
   end

   assign rise = rise_r;

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Walks the enabled channels, arms the buffer block on each, and reports the
// captured average against a pass window.
module freq_sweep_ctrl
   import freq_pkg::*;
#(
   parameter int CHANNELS       = DEF_CHANNELS,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int ARM_CYCLES     = DEF_ARM_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CLEAR_CYCLES   = DEF_CLEAR_CYCLES
) (
   input  logic                        Clock,
   input  logic                        nReset,
   input  logic                        start,
   input  logic                        abort,
   input  logic [CHANNELS-1:0]         chan_mask,
   input  logic [15:0]                 samples_req,
   input  logic [9:0]                  lo_limit,
   input  logic [9:0]                  hi_limit,
   output logic                        meas_enable,
   output logic [15:0]                 meas_samples,
   output logic                        buf_nreset,
   output logic [$clog2(CHANNELS)-1:0] chan_sel,
   input  logic                        meas_done,
   input  logic [9:0]                  meas_avg,
   output logic                        busy,
   output logic                        result_valid,
   output logic [CHAN_W_MAX-1:0]       result_chan,
   output logic [9:0]                  result_avg,
   output logic                        result_pass,
   output logic                        result_timeout,
   output logic                        sweep_done
);

   localparam int CW = $clog2(CHANNELS);
   localparam int SW = $clog2(SETTLE_CYCLES);
   localparam int AW = $clog2(ARM_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int LW = $clog2(CLEAR_CYCLES);

   sweep_state_t     state_r;
   sweep_result_t    result_r;
   logic [CHANNELS-1:0] mask_r;
   logic [9:0]       lo_r, hi_r;
   logic [15:0]      samples_r;
   logic [CW-1:0]    chan_r, first_idx_s, next_idx_s;
   logic             next_found_s, abort_pend_r, done_rise_s;
   logic             en_r, bufn_r, busy_r, valid_r, done_r;
   logic [SW-1:0]    settle_cnt_r;
   logic [AW-1:0]    arm_cnt_r;
   logic [TW-1:0]    wait_cnt_r;
   logic [LW-1:0]    clear_cnt_r;

   sync_edge u_done_sync (
      .Clock    (Clock),
      .nReset   (nReset),
      .async_in (meas_done),
      .rise     (done_rise_s)
   );

   // Lowest set bit of the incoming mask; next latched bit above the current channel (no wrap).
   always_comb begin
      first_idx_s  = {CW{1'b0}};
      next_idx_s   = {CW{1'b0}};
      next_found_s = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         first_idx_s  = chan_mask[i] ? CW'(i) : first_idx_s;
         next_found_s = next_found_s | (mask_r[i] & (i > int'(chan_r)));
         next_idx_s   = (mask_r[i] && (i > int'(chan_r))) ? CW'(i) : next_idx_s;
      end
   end

   // Sweep sequencer with registered outputs.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state_r      <= ST_IDLE;
         result_r     <= '{chan: 4'd0, avg: 10'd0, pass: 1'b0, timeout: 1'b0};
         mask_r       <= {CHANNELS{1'b0}};
         lo_r         <= 10'd0;
         hi_r         <= 10'd0;
         samples_r    <= 16'd0;
         chan_r       <= {CW{1'b0}};
         abort_pend_r <= 1'b0;
         en_r         <= 1'b0;
         bufn_r       <= 1'b1;
         busy_r       <= 1'b0;
         valid_r      <= 1'b0;
         done_r       <= 1'b0;
         settle_cnt_r <= {SW{1'b0}};
         arm_cnt_r    <= {AW{1'b0}};
         wait_cnt_r   <= {TW{1'b0}};
         clear_cnt_r  <= {LW{1'b0}};
      end else begin
         valid_r <= 1'b0;
         done_r  <= 1'b0;
         if (abort && (state_r != ST_IDLE)) begin
            state_r      <= ST_CLEAR;
            abort_pend_r <= 1'b1;
            en_r         <= 1'b0;
            bufn_r       <= 1'b0;
            clear_cnt_r  <= {LW{1'b0}};
         end else begin
            case (state_r)
               ST_IDLE: begin
                  busy_r <= 1'b0;
                  if (start && !abort && !busy_r) begin
                     mask_r    <= chan_mask;
                     samples_r <= samples_req;
                     lo_r      <= lo_limit;
                     hi_r      <= hi_limit;
                     busy_r    <= 1'b1;
                     if ((chan_mask == {CHANNELS{1'b0}}) || (samples_req == 16'd0)) begin
                        state_r <= ST_DONE;
                     end else begin
                        chan_r       <= first_idx_s;
                        settle_cnt_r <= {SW{1'b0}};
                        state_r      <= ST_SETTLE;
                     end
                  end
               end
               ST_SETTLE: begin
                  if (settle_cnt_r == SW'(SETTLE_CYCLES - 1)) begin
                     en_r      <= 1'b1;
                     arm_cnt_r <= {AW{1'b0}};
                     state_r   <= ST_ARM;
                  end else begin
                     settle_cnt_r <= settle_cnt_r + SW'(1);
                  end
               end
               ST_ARM: begin
                  if (arm_cnt_r == AW'(ARM_CYCLES - 1)) begin
                     en_r       <= 1'b0;
                     wait_cnt_r <= {TW{1'b0}};
                     state_r    <= ST_WAIT;
                  end else begin
                     arm_cnt_r <= arm_cnt_r + AW'(1);
                  end
               end
               ST_WAIT: begin
                  if (done_rise_s) begin
                     state_r <= ST_CAPTURE;
                  end else if (wait_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                     result_r <= '{chan: 4'(chan_r), avg: 10'd0, pass: 1'b0, timeout: 1'b1};
                     valid_r  <= 1'b1;
                     state_r  <= ST_REPORT;
                  end else begin
                     wait_cnt_r <= wait_cnt_r + TW'(1);
                  end
               end
               ST_CAPTURE: begin
                  result_r <= '{chan: 4'(chan_r), avg: meas_avg,
                                pass: in_window(meas_avg, lo_r, hi_r), timeout: 1'b0};
                  valid_r  <= 1'b1;
                  state_r  <= ST_REPORT;
               end
               ST_REPORT: begin
                  if (result_r.timeout) begin
                     // A timed-out buffer may still be mid-measurement; flush it first.
                     bufn_r       <= 1'b0;
                     clear_cnt_r  <= {LW{1'b0}};
                     abort_pend_r <= 1'b0;
                     state_r      <= ST_CLEAR;
                  end else if (next_found_s) begin
                     chan_r       <= next_idx_s;
                     settle_cnt_r <= {SW{1'b0}};
                     state_r      <= ST_SETTLE;
                  end else begin
                     state_r <= ST_DONE;
                  end
               end
               ST_CLEAR: begin
                  if (clear_cnt_r == LW'(CLEAR_CYCLES - 1)) begin
                     bufn_r <= 1'b1;
                     if (abort_pend_r) begin
                        abort_pend_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                     end else if (next_found_s) begin
                        chan_r       <= next_idx_s;
                        settle_cnt_r <= {SW{1'b0}};
                        state_r      <= ST_SETTLE;
                     end else begin
                        state_r <= ST_DONE;
                     end
                  end else begin
                     clear_cnt_r <= clear_cnt_r + LW'(1);
                  end
               end
               ST_DONE: begin
                  done_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign meas_enable    = en_r;
   assign meas_samples   = samples_r;
   assign buf_nreset     = bufn_r;
   assign chan_sel       = chan_r;
   assign busy           = busy_r;
   assign result_valid   = valid_r;
   assign result_chan    = result_r.chan;
   assign result_avg     = result_r.avg;
   assign result_pass    = result_r.pass;
   assign result_timeout = result_r.timeout;
   assign sweep_done     = done_r;

endmodule
